// File: rtl/screen_compositor_pkg.sv
// screen_pkg: shared constants and the double-dabble step for the screen compositor
package screen_pkg;
    localparam logic [1:0] TITLE = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] OVER  = 2'd2;

    localparam logic [7:0] BG_COLOUR_DEF = 8'h00;
    localparam logic [7:0] TRANSP_DEF    = 8'hE3;

    localparam int DIGIT_W = 8;
    localparam int DIGIT_N = 10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // One double-dabble iteration on {tens, ones, binary}: correct nibbles >= 5, then shift left
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] a;
        a = v;
        if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
        if (a[10:7]  >= 4'd5) a[10:7]  = a[10:7]  + 4'd3;
        return {a[13:0], 1'b0};
    endfunction
endpackage

// File: rtl/screen_compositor_bin2bcd_seq.sv
// bin2bcd_seq: 7-bit binary to two BCD digits, one double-dabble shift per cycle
module bin2bcd_seq
    import screen_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [6:0] i_bin,
    output logic [7:0] o_bcd,
    output logic       o_busy,
    output logic       o_done
);
    logic [1:0]  r_state;
    logic [14:0] r_work;
    logic [2:0]  r_cnt;

    // Converter FSM: capture on start when idle, seven shifts, then one commit cycle
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_work  <= {8'd0, i_bin};
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_work  <= dd_step(r_work);
                    r_cnt   <= r_cnt + 3'd1;
                    r_state <= (r_cnt == 3'd6) ? S_COMMIT : S_SHIFT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_bcd  = r_work[14:7];
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_COMMIT);
endmodule

// File: rtl/screen_compositor.sv
// screen_compositor: layer selection by game state, per-frame score to BCD, registered pixel out
module screen_compositor
    import screen_pkg::*;
#(
    parameter logic [7:0] BG_COLOUR = BG_COLOUR_DEF,
    parameter logic [7:0] TRANSP    = TRANSP_DEF,
    parameter int         SCORE_MAX = 99
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_aactive,
    input  logic                       i_frame_start,
    input  logic [1:0]                 i_game_state,
    input  logic [6:0]                 i_score,
    input  logic                       i_bspriteon,
    input  logic [7:0]                 i_bdata,
    input  logic                       i_gspriteon,
    input  logic [7:0]                 i_gdata,
    input  logic                       i_tens_on,
    input  logic                       i_ones_on,
    input  logic [DIGIT_N*DIGIT_W-1:0] i_digit_data,
    output logic [7:0]                 o_pixel,
    output logic [3:0]                 o_tens,
    output logic [3:0]                 o_ones,
    output logic                       o_score_busy
);
    logic [6:0]         w_score_sat;
    logic [7:0]         w_bcd;
    logic               w_done;
    logic [DIGIT_W-1:0] w_digit [DIGIT_N];
    logic [7:0]         w_tens_px, w_ones_px, w_sel;
    logic               w_b_op, w_g_op, w_t_op, w_o_op;
    logic [3:0]         r_tens, r_ones;
    logic [7:0]         r_pixel;

    assign w_score_sat = (i_score > 7'(SCORE_MAX)) ? 7'(SCORE_MAX) : i_score;

    bin2bcd_seq u_bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_frame_start),
        .i_bin   (w_score_sat),
        .o_bcd   (w_bcd),
        .o_busy  (o_score_busy),
        .o_done  (w_done)
    );

    // Displayed digits change only on the commit cycle so no partial result is ever shown
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (w_done) begin
            r_tens <= w_bcd[7:4];
            r_ones <= w_bcd[3:0];
        end
    end

    for (genvar d = 0; d < DIGIT_N; d++) begin : g_dig
        assign w_digit[d] = i_digit_data[d*DIGIT_W +: DIGIT_W];
    end

    assign w_tens_px = w_digit[r_tens];
    assign w_ones_px = w_digit[r_ones];
    assign w_b_op    = i_bspriteon && (i_bdata   != TRANSP);
    assign w_g_op    = i_gspriteon && (i_gdata   != TRANSP);
    assign w_t_op    = i_tens_on   && (w_tens_px != TRANSP);
    assign w_o_op    = i_ones_on   && (w_ones_px != TRANSP);

    assign w_sel = !i_aactive                 ? 8'h00 :
                   (i_game_state == TITLE)    ? (w_b_op ? i_bdata : BG_COLOUR) :
                   (i_game_state == PLAY)     ? (w_t_op ? w_tens_px : w_o_op ? w_ones_px : BG_COLOUR) :
                   (i_game_state == OVER)     ? (w_t_op ? w_tens_px : w_o_op ? w_ones_px :
                                                 w_g_op ? i_gdata : BG_COLOUR) :
                                                BG_COLOUR;

    // Single output pipeline stage
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_pixel <= 8'h00;
        else        r_pixel <= w_sel;
    end

    assign o_pixel = r_pixel;
    assign o_tens  = r_tens;
    assign o_ones  = r_ones;
endmodule

// File: tb/tb_screen_compositor.sv
// tb_screen_compositor: directed checks of conversion timing, layer priority and reset behaviour
module tb_screen_compositor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aactive = 1'b1, frame_start = 1'b0;
    logic [1:0]  game_state = 2'd0;
    logic [6:0]  score = '0;
    logic        bspriteon = 1'b1, gspriteon = 1'b0, tens_on = 1'b0, ones_on = 1'b0;
    logic [7:0]  bdata = 8'h55, gdata = 8'h00;
    logic [79:0] digit_data = {10{8'hE3}};
    logic [7:0]  pixel;
    logic [3:0]  tens, ones;
    logic        busy;
    int          n_chk = 0, n_pass = 0;

    screen_compositor dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_aactive     (aactive),
        .i_frame_start (frame_start),
        .i_game_state  (game_state),
        .i_score       (score),
        .i_bspriteon   (bspriteon),
        .i_bdata       (bdata),
        .i_gspriteon   (gspriteon),
        .i_gdata       (gdata),
        .i_tens_on     (tens_on),
        .i_ones_on     (ones_on),
        .i_digit_data  (digit_data),
        .o_pixel       (pixel),
        .o_tens        (tens),
        .o_ones        (ones),
        .o_score_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digit(input int n, input logic [7:0] v);
        digit_data[n*8 +: 8] = v;
    endtask

    task automatic convert(input logic [6:0] s, input logic [3:0] et, input logic [3:0] eo);
        logic [3:0] pt, po;
        pt = tens;
        po = ones;
        score = s;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("busy_c%0d_s%0d", i, s), busy, 1);
            chk($sformatf("hold_c%0d_s%0d", i, s), {tens, ones}, {pt, po});
            tick();
        end
        chk($sformatf("idle_s%0d", s), busy, 0);
        chk($sformatf("tens_s%0d", s), tens, et);
        chk($sformatf("ones_s%0d", s), ones, eo);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_pixel", pixel, 8'h00);
        chk("rst_tens", tens, 0);
        chk("rst_ones", ones, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        chk("rel_pixel_pre", pixel, 8'h00);
        tick();
        chk("rel_pixel_post", pixel, 8'h55);

        convert(7'd57, 4'd5, 4'd7);
        convert(7'd120, 4'd9, 4'd9);
        convert(7'd10, 4'd1, 4'd0);
        convert(7'd0, 4'd0, 4'd0);

        // second pulse at cycle 3 of a conversion is ignored
        score = 7'd34;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (2) tick();
        score = 7'd80;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
        chk("ign_busy", busy, 0);
        chk("ign_tens", tens, 3);
        chk("ign_ones", ones, 4);
        tick();
        chk("ign_no_restart", busy, 0);

        // layer priority in OVER (tens=3, ones=4)
        game_state = 2'd2;
        bspriteon = 1'b0;
        gspriteon = 1'b1;
        gdata = 8'h1C;
        tens_on = 1'b1;
        set_digit(3, 8'hFF);
        tick();
        chk("over_tens", pixel, 8'hFF);
        set_digit(3, 8'hE3);
        tick();
        chk("over_gsprite", pixel, 8'h1C);
        ones_on = 1'b1;
        set_digit(4, 8'h42);
        tick();
        chk("over_ones", pixel, 8'h42);
        gspriteon = 1'b0;
        ones_on = 1'b0;
        tick();
        chk("over_bg", pixel, 8'h00);

        // PLAY: tens beats ones, game-over sprite not shown
        game_state = 2'd1;
        gspriteon = 1'b1;
        tens_on = 1'b1;
        ones_on = 1'b1;
        set_digit(3, 8'h11);
        tick();
        chk("play_tens", pixel, 8'h11);
        set_digit(3, 8'hE3);
        tick();
        chk("play_ones", pixel, 8'h42);
        ones_on = 1'b0;
        tick();
        chk("play_no_gsprite", pixel, 8'h00);

        // TITLE and blanking
        game_state = 2'd0;
        bspriteon = 1'b1;
        bdata = 8'hE3;
        tick();
        chk("title_transp", pixel, 8'h00);
        bdata = 8'h6D;
        tick();
        chk("title_sprite", pixel, 8'h6D);
        aactive = 1'b0;
        tick();
        chk("blank", pixel, 8'h00);
        aactive = 1'b1;
        game_state = 2'd3;
        tick();
        chk("reserved", pixel, 8'h00);
        game_state = 2'd0;
        tick();
        chk("title_again", pixel, 8'h6D);

        // reset at cycle 4 of a conversion
        score = 7'd57;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_tens", tens, 0);
        chk("mid_rst_ones", ones, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pixel", pixel, 8'h00);
        tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_tens", tens, 0);
        convert(7'd99, 4'd9, 4'd9);
        convert(7'd68, 4'd6, 4'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
